// File: rtl/bp_fe_fetch_buffer_if.sv
// Handshake and data bundle between the PC generator, the fetch buffer and the FE-queue packer.
// The slave modport is the buffer's view; the master modport is the surrounding fetch logic.
interface bp_fe_fetch_buffer_if #(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int metadata_width_p = 36,
    parameter int els_p            = 4
);
    localparam int count_width_lp = $clog2(els_p + 1);

    logic                        enq_v_i;
    logic                        enq_ready_o;
    logic [vaddr_width_p-1:0]    enq_pc_i;
    logic [instr_width_p-1:0]    enq_instr_i;
    logic [metadata_width_p-1:0] enq_metadata_i;
    logic                        enq_exc_i;
    logic                        flush_i;
    logic                        deq_v_o;
    logic                        deq_yumi_i;
    logic [vaddr_width_p-1:0]    deq_pc_o;
    logic [instr_width_p-1:0]    deq_instr_o;
    logic [metadata_width_p-1:0] deq_metadata_o;
    logic                        deq_exc_o;
    logic [count_width_lp-1:0]   count_o;
    logic                        exc_hold_o;

    modport slave (
        input  enq_v_i, enq_pc_i, enq_instr_i, enq_metadata_i, enq_exc_i,
        input  flush_i, deq_yumi_i,
        output enq_ready_o, deq_v_o, deq_pc_o, deq_instr_o, deq_metadata_o,
        output deq_exc_o, count_o, exc_hold_o
    );

    modport master (
        output enq_v_i, enq_pc_i, enq_instr_i, enq_metadata_i, enq_exc_i,
        output flush_i, deq_yumi_i,
        input  enq_ready_o, deq_v_o, deq_pc_o, deq_instr_o, deq_metadata_o,
        input  deq_exc_o, count_o, exc_hold_o
    );
endinterface

// File: rtl/bp_fe_fetch_buffer.sv
// Flushable in-order fetch buffer: stores {pc, instr, metadata, exc} per fetch and stops
// accepting new fetches after a faulting one until that entry has been consumed.
module bp_fe_fetch_buffer #(
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int metadata_width_p = 36,
    parameter int els_p            = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_fe_fetch_buffer_if.slave   io
);
    localparam int PTR_W   = $clog2(els_p);
    localparam int CNT_W   = $clog2(els_p + 1);
    localparam int ENTRY_W = vaddr_width_p + instr_width_p + metadata_width_p + 1;

    // Field offsets inside a packed entry: exc is the LSB, pc the top field
    localparam int META_LO  = 1;
    localparam int INSTR_LO = META_LO + metadata_width_p;
    localparam int PC_LO    = INSTR_LO + instr_width_p;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [0:0]        r_state;

    logic [PTR_W-1:0]  w_wptr_next;
    logic [PTR_W-1:0]  w_rptr_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [0:0]        w_state_next;

    logic              w_full;
    logic              w_empty;
    logic              w_enq_ready;
    logic              w_deq_v;
    logic              w_enq_fire;
    logic              w_deq_fire;
    logic [ENTRY_W-1:0] w_enq_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [els_p-1:0][ENTRY_W-1:0] w_entries;

    // Ready/valid come only from registered state so neither loops back through the flush/yumi inputs
    assign w_full      = (r_count == CNT_W'(els_p));
    assign w_empty     = (r_count == '0);
    assign w_enq_ready = ~w_full & (r_state == ST_RUN);
    assign w_deq_v     = ~w_empty;
    assign w_enq_fire  = io.enq_v_i & w_enq_ready & ~io.flush_i;
    assign w_deq_fire  = io.deq_yumi_i & w_deq_v & ~io.flush_i;

    assign w_enq_entry = {io.enq_pc_i, io.enq_instr_i, io.enq_metadata_i, io.enq_exc_i};

    genvar gi;
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_entry
            logic [ENTRY_W-1:0] r_entry;

            always_ff @(posedge clk_i) begin
                if (w_enq_fire && (r_wptr == PTR_W'(gi))) begin
                    r_entry <= w_enq_entry;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    assign w_head = w_entries[r_rptr];

    always_comb begin
        w_wptr_next  = r_wptr + PTR_W'(w_enq_fire);
        w_rptr_next  = r_rptr + PTR_W'(w_deq_fire);
        w_count_next = r_count + CNT_W'(w_enq_fire) - CNT_W'(w_deq_fire);
        w_state_next = r_state;
        if (r_state == ST_RUN) begin
            if (w_enq_fire && io.enq_exc_i) begin
                w_state_next = ST_HOLD;
            end
        end else begin
            // Only the faulting entry leaving the head releases fetch
            if (w_deq_fire && w_head[0]) begin
                w_state_next = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
        end else if (io.flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
        end else begin
            r_wptr  <= w_wptr_next;
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_state <= w_state_next;
        end
    end

    assign io.enq_ready_o    = w_enq_ready;
    assign io.deq_v_o        = w_deq_v;
    assign io.deq_pc_o       = w_head[PC_LO +: vaddr_width_p];
    assign io.deq_instr_o    = w_head[INSTR_LO +: instr_width_p];
    assign io.deq_metadata_o = w_head[META_LO +: metadata_width_p];
    assign io.deq_exc_o      = w_head[0];
    assign io.count_o        = r_count;
    assign io.exc_hold_o     = (r_state == ST_HOLD);
endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Directed and randomized bench for bp_fe_fetch_buffer against a queue-based reference model.
module tb_bp_fe_fetch_buffer;
    localparam int VW  = 39;
    localparam int IW  = 32;
    localparam int MW  = 36;
    localparam int ELS = 4;
    localparam int CW  = $clog2(ELS + 1);

    typedef struct {
        logic [VW-1:0] pc;
        logic [IW-1:0] instr;
        logic [MW-1:0] meta;
        bit            exc;
    } ent_t;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b1;
    int   n_tests   = 0;
    int   n_fail    = 0;
    ent_t q[$];

    always #5 clk_i = ~clk_i;

    bp_fe_fetch_buffer_if #(
        .vaddr_width_p(VW), .instr_width_p(IW), .metadata_width_p(MW), .els_p(ELS)
    ) io ();

    bp_fe_fetch_buffer #(
        .vaddr_width_p(VW), .instr_width_p(IW), .metadata_width_p(MW), .els_p(ELS)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .io       (io)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fetch is blocked exactly while a faulting fetch is still somewhere in the buffer
    function automatic bit model_hold();
        foreach (q[i]) if (q[i].exc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        bit hold;
        hold = model_hold();
        chk("count", 64'(io.count_o), 64'(q.size()));
        chk("deq_v", 64'(io.deq_v_o), 64'(q.size() != 0));
        chk("enq_ready", 64'(io.enq_ready_o), 64'((q.size() < ELS) && !hold));
        chk("exc_hold", 64'(io.exc_hold_o), 64'(hold));
        if (q.size() != 0) begin
            chk("deq_pc", 64'(io.deq_pc_o), 64'(q[0].pc));
            chk("deq_exc", 64'(io.deq_exc_o), 64'(q[0].exc));
            chk("deq_meta", 64'(io.deq_metadata_o), 64'(q[0].meta));
            if (!q[0].exc) chk("deq_instr", 64'(io.deq_instr_o), 64'(q[0].instr));
        end
    endtask

    // One clock cycle: check outputs, drive the cycle's inputs, update the model at the edge
    task automatic cycle(input bit ev, input logic [VW-1:0] pc, input bit exc,
                         input bit yumi, input bit fl);
        logic [63:0] r64;
        ent_t        e;
        bit          acc;
        check_outputs();
        r64 = {$urandom(), $urandom()};
        e.pc    = pc;
        e.instr = r64[IW-1:0];
        e.meta  = r64[63 -: MW];
        e.exc   = exc;
        io.enq_v_i        = ev;
        io.enq_pc_i       = e.pc;
        io.enq_instr_i    = e.instr;
        io.enq_metadata_i = e.meta;
        io.enq_exc_i      = exc;
        io.deq_yumi_i     = yumi;
        io.flush_i        = fl;
        acc = ev && (q.size() < ELS) && !model_hold();
        @(posedge clk_i);
        if (fl) begin
            q.delete();
        end else begin
            if (yumi && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk_i);
        io.enq_v_i    = 1'b0;
        io.deq_yumi_i = 1'b0;
        io.flush_i    = 1'b0;
        io.enq_exc_i  = 1'b0;
    endtask

    initial begin
        logic [VW-1:0] pc;
        bit            ev;
        bit            yumi;
        io.enq_v_i = 1'b0; io.enq_pc_i = '0; io.enq_instr_i = '0; io.enq_metadata_i = '0;
        io.enq_exc_i = 1'b0; io.flush_i = 1'b0; io.deq_yumi_i = 1'b0;

        #1 reset_n_i = 1'b0;
        @(negedge clk_i);
        chk("rst_count", 64'(io.count_o), 64'(0));
        chk("rst_deq_v", 64'(io.deq_v_o), 64'(0));
        chk("rst_enq_ready", 64'(io.enq_ready_o), 64'(1));
        chk("rst_exc_hold", 64'(io.exc_hold_o), 64'(0));
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // Fill to full, try one more, then drain in order
        for (int i = 0; i < 4; i++) cycle(1, VW'(32'h100 + 4 * i), 0, 0, 0);
        cycle(1, VW'(32'h110), 0, 0, 0);
        chk("full_count", 64'(io.count_o), 64'(4));
        chk("full_ready", 64'(io.enq_ready_o), 64'(0));
        cycle(1, VW'(32'h114), 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 0, 0);

        // Steady occupancy 2 across pointer wrap
        cycle(1, VW'(32'h500), 0, 0, 0);
        cycle(1, VW'(32'h504), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, VW'(32'h508 + 4 * i), 0, 1, 0);
        chk("steady_count", 64'(io.count_o), 64'(2));
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);

        // Flush with simultaneous enqueue and dequeue
        for (int i = 0; i < 3; i++) cycle(1, VW'(32'h180 + 4 * i), 0, 0, 0);
        cycle(1, VW'(32'h200), 0, 1, 1);
        chk("flush_count", 64'(io.count_o), 64'(0));
        chk("flush_ready", 64'(io.enq_ready_o), 64'(1));
        cycle(0, '0, 0, 0, 0);

        // Exception entry blocks fetch until it drains
        cycle(1, VW'(32'h300), 0, 0, 0);
        cycle(1, VW'(32'h304), 1, 0, 0);
        cycle(1, VW'(32'h308), 0, 0, 0);
        chk("hold_set", 64'(io.exc_hold_o), 64'(1));
        cycle(1, VW'(32'h308), 0, 1, 0);
        cycle(1, VW'(32'h308), 0, 1, 0);
        chk("hold_clear", 64'(io.exc_hold_o), 64'(0));
        chk("hold_clear_ready", 64'(io.enq_ready_o), 64'(1));
        cycle(0, '0, 0, 0, 0);

        // Flush out of HOLD
        cycle(1, VW'(32'h600), 0, 0, 0);
        cycle(1, VW'(32'h604), 1, 0, 0);
        cycle(0, '0, 0, 0, 1);
        chk("hold_flush", 64'(io.exc_hold_o), 64'(0));
        cycle(0, '0, 0, 0, 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle(1, VW'(32'h700 + 4 * i), 0, 0, 0);
        check_outputs();
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_count", 64'(io.count_o), 64'(0));
        chk("arst_deq_v", 64'(io.deq_v_o), 64'(0));
        chk("arst_ready", 64'(io.enq_ready_o), 64'(1));
        q.delete();
        #1 reset_n_i = 1'b1;
        @(negedge clk_i);
        cycle(1, VW'(32'h400), 0, 0, 0);
        chk("post_rst_pc", 64'(io.deq_pc_o), 64'(32'h400));
        cycle(0, '0, 0, 1, 0);

        // Randomized traffic
        pc = VW'(32'h1000);
        for (int i = 0; i < 400; i++) begin
            ev   = ($urandom_range(0, 9) < 7);
            yumi = (q.size() != 0) && ($urandom_range(0, 9) < 6);
            cycle(ev, pc, ($urandom_range(0, 15) == 0), yumi, ($urandom_range(0, 31) == 0));
            pc = pc + VW'(4);
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_fe_fetch_buffer.md
# bp_fe_fetch_buffer

Small flushable FIFO directly downstream of the front-end PC generator. It captures each fetched instruction with its fetch PC, branch metadata and exception flag, and presents them in order to the FE-queue packer. It decouples fetch from backend backpressure, drops all in-flight entries on a redirect, and blocks further fetch after a faulting fetch until that fetch has drained.

## Interface
- vaddr_width_p, 39, fetch PC width
- instr_width_p, 32, instruction width
- metadata_width_p, 36, branch-metadata-forward width
- els_p, 4, entry count; power of two, ≥2

- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- enq_v_i  in  1  fetch result valid
- enq_ready_o  out  1  buffer can accept this cycle
- enq_pc_i  in  vaddr_width_p  fetch PC
- enq_instr_i  in  instr_width_p  fetched instruction (don't-care when enq_exc_i=1)
- enq_metadata_i  in  metadata_width_p  branch metadata
- enq_exc_i  in  1  fetch raised an exception
- flush_i  in  1  redirect: discard all contents
- deq_v_o  out  1  head entry valid
- deq_yumi_i  in  1  consumer takes head; legal only when deq_v_o=1
- deq_pc_o  out  vaddr_width_p  head PC
- deq_instr_o  out  instr_width_p  head instruction
- deq_metadata_o  out  metadata_width_p  head metadata
- deq_exc_o  out  1  head is an exception entry
- count_o  out  $clog2(els_p+1)  occupancy
- exc_hold_o  out  1  enqueue blocked by pending exception

## Operation
- Storage: els_p entries of {pc, instr, metadata, exc}, plus write pointer wptr, read pointer rptr ($clog2(els_p) bits each, wrap modulo els_p) and count register.
- Enqueue fires when enq_v_i & enq_ready_o & ~flush_i: write the entry at wptr, then wptr+1.
- Dequeue fires when deq_yumi_i & deq_v_o & ~flush_i: rptr+1.
- count_next = count + enq_fire − deq_fire. Simultaneous enq/deq leaves count unchanged, including when count=els_p-1.
- enq_ready_o = (count != els_p) & (state == RUN). There is no bypass: when full, enq_ready_o=0 even if deq_yumi_i=1 in the same cycle.
- deq_v_o = (count != 0). The deq_* data outputs show the entry at rptr and are undefined when deq_v_o=0.
- State machine:
  - RUN → HOLD on an enqueue fire with enq_exc_i=1.
  - HOLD → RUN on a dequeue fire of an entry with exc=1, or on flush_i.
  - exc_hold_o = (state == HOLD).
- flush_i has highest priority. On flush, in the next cycle: wptr=rptr=0, count=0, state=RUN. Any enqueue or dequeue presented in the flush cycle is ignored, and the memory contents are don't-care.
- Reset (reset_n_i=0, applied asynchronously): wptr=rptr=0, count=0, state=RUN. The storage array itself is not reset. Outputs during and after reset: deq_v_o=0, count_o=0, exc_hold_o=0, enq_ready_o=1.
- Asserting reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Enqueue-to-visible latency is 1 cycle: an entry accepted at edge N drives deq_v_o=1 and its data in the cycle after edge N.
- enq_ready_o and deq_v_o are combinational only from registered state. Neither depends on the enq_v_i, deq_yumi_i or flush_i inputs of the same cycle.
- count_o is a registered value.
- A flush asserted in cycle N gives deq_v_o=0 and enq_ready_o=1 in cycle N+1.
- Throughput is one enqueue and one dequeue per cycle at any occupancy between 1 and els_p-1.
- The exception entry itself is enqueued. enq_ready_o drops starting the cycle after that enqueue.
- Sustained full throughput wraps the pointers from els_p-1 to 0 with no bubble.

## Test plan
- Reset, then enqueue PCs 0x100, 0x104, 0x108, 0x10C on consecutive cycles with no dequeue. Expect count_o to go 1, 2, 3, 4, then enq_ready_o=0 with count_o=4. Dequeue all four and expect the PCs in order 0x100 to 0x10C, then deq_v_o=0.
- Keep occupancy at 2 while doing one enqueue and one dequeue per cycle for 10 cycles, with PCs incrementing by 4. Expect count_o to stay 2, the output order to be preserved across pointer wrap, and no dropped entries.
- Fill the buffer to 3 entries, then in one cycle assert flush_i together with enq_v_i (PC 0x200) and deq_yumi_i. Next cycle expect count_o=0, deq_v_o=0 and enq_ready_o=1, and 0x200 must never appear at the output.
- Enqueue 0x300 (exc=0), then 0x304 (exc=1). Expect exc_hold_o=1 and enq_ready_o=0 while enq_v_i stays high. Dequeue 0x300, then 0x304 with deq_exc_o=1; the cycle after that dequeue, expect exc_hold_o=0 and enq_ready_o=1.
- Enter HOLD with 2 entries buffered, then assert flush_i. Next cycle expect exc_hold_o=0, count_o=0 and enq_ready_o=1.
- With 3 entries buffered, pulse reset_n_i low between clock edges. Expect deq_v_o=0 and count_o=0 immediately, with no clock edge needed; after release, an enqueue of 0x400 is visible at the output the next cycle.
